// File: rtl/alu_pkg.sv
// Shared types for the slice-serial ALU: 4-bit opcode set, FSM states, default slice width.
package alu_pkg;

    localparam int unsigned SLICE_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUBWB  = 4'h1,
        OP_MOV    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_ADDINC = 4'h6,
        OP_RSV7   = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_MOVB   = 4'hC,
        OP_LSHL   = 4'hD,
        OP_RSVE   = 4'hE,
        OP_RSVF   = 4'hF
    } optype_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Carry-in seeded into the lowest slice; the shift-in for lshl is zero.
    function automatic logic cin_init(input optype_e op);
        return (op == OP_SUB) || (op == OP_INC) || (op == OP_ADDINC);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; cin doubles as the shift-in bit for lshl.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = SLICE_DEFAULT
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  optype_e          opcode,
    output logic [SLICE-1:0] r,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    logic [SLICE-1:0] bp;
    logic [SLICE:0]   sum;
    logic             arith;

    always_comb begin
        bp    = '0;
        arith = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDINC: begin bp = b;  arith = 1'b1; end
            OP_SUBWB, OP_SUB:  begin bp = ~b; arith = 1'b1; end
            OP_MOV, OP_INC:    begin bp = '0; arith = 1'b1; end
            OP_DEC:            begin bp = '1; arith = 1'b1; end
            default:           ;
        endcase

        sum  = {1'b0, a} + {1'b0, bp} + {{SLICE{1'b0}}, cin};
        r    = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        if (arith) begin
            r    = sum[SLICE-1:0];
            cout = sum[SLICE];
            ovf  = (a[SLICE-1] == bp[SLICE-1]) && (r[SLICE-1] != a[SLICE-1]);
        end else begin
            case (opcode)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_NOT:  r = ~a;
                OP_MOVB: r = b;
                OP_LSHL: begin
                    r    = {a[SLICE-2:0], cin};
                    cout = a[SLICE-1];
                end
                default: r = '0;
            endcase
        end
        zero = (r == '0);
    end

endmodule

// File: rtl/alu_seq_128.sv
// Slice-serial ALU responder: accepts one request, computes LSB-first one slice per cycle,
// then holds result/flags on a valid/ready response channel.
module alu_seq_128
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH = 128,
    parameter int unsigned SLICE  = SLICE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [2:0]        opsel,
    input  logic              mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag
);

    localparam int unsigned NSLICE = DWIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (DWIDTH % SLICE != 0) begin : g_width_check
        $fatal(1, "alu_seq_128: DWIDTH must be a multiple of SLICE");
    end

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [DWIDTH-1:0] a_q, a_d, b_q, b_d;
    optype_e           op_q, op_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              c_q, c_d, z_q, z_d, o_q, o_d;

    logic [SLICE-1:0]  sl_r;
    logic              sl_cout, sl_zero, sl_ovf;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a      (a_q[idx_q*SLICE +: SLICE]),
        .b      (b_q[idx_q*SLICE +: SLICE]),
        .cin    (carry_q),
        .opcode (op_q),
        .r      (sl_r),
        .cout   (sl_cout),
        .zero   (sl_zero),
        .ovf    (sl_ovf)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign o_flag    = o_q;
    assign s_flag    = result_q[DWIDTH-1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        o_d      = o_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    a_d     = op1;
                    b_d     = op2;
                    op_d    = optype_e'({mode, opsel});
                    idx_d   = '0;
                    carry_d = cin_init(optype_e'({mode, opsel}));
                    c_d     = 1'b0;
                    z_d     = 1'b1;
                    o_d     = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // c/o track the latest slice, so after the top slice they hold the final values.
                result_d[idx_q*SLICE +: SLICE] = sl_r;
                carry_d = sl_cout;
                c_d     = sl_cout;
                o_d     = sl_ovf;
                z_d     = z_q & sl_zero;
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            o_q      <= o_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

endmodule

// File: tb/tb_alu_seq_128.sv
// Self-checking bench for alu_seq_128: directed corner cases plus random ops against a
// whole-word arithmetic reference model.
module tb_alu_seq_128;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] op1, op2;
    logic [2:0]   opsel;
    logic         mode;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] result;
    logic         c_flag, z_flag, o_flag, s_flag;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_128 #(.DWIDTH(128), .SLICE(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .mode      (mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .o_flag    (o_flag),
        .s_flag    (s_flag)
    );

    // Returns {result[127:0], c, z, o, s}.
    function automatic logic [131:0] ref_model(input logic [127:0] a, input logic [127:0] b,
                                               input logic [3:0] opc);
        logic [128:0] sum;
        logic [127:0] bp, r;
        logic         cin, c, o;
        bp = '0; cin = 1'b0; r = '0; c = 1'b0; o = 1'b0;
        if (opc <= 4'd6) begin
            case (opc)
                4'd0: bp = b;
                4'd1: bp = ~b;
                4'd3: begin bp = ~b; cin = 1'b1; end
                4'd4: cin = 1'b1;
                4'd5: bp = '1;
                4'd6: begin bp = b; cin = 1'b1; end
                default: bp = '0;
            endcase
            sum = a + bp + cin;
            r   = sum[127:0];
            c   = sum[128];
            o   = (a[127] == bp[127]) && (r[127] != a[127]);
        end else begin
            case (opc)
                4'h8: r = a & b;
                4'h9: r = a | b;
                4'hA: r = a ^ b;
                4'hB: r = ~a;
                4'hC: r = b;
                4'hD: begin r = a << 1; c = a[127]; end
                default: r = '0;
            endcase
        end
        return {r, c, (r == 128'd0), o, r[127]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic [3:0] opc,
                          input int unsigned hold, input string tag);
        logic [131:0] exp;
        int unsigned  lat;
        bit           got;
        exp = ref_model(a, b, opc);
        @(negedge clk);
        op1 = a; op2 = b; opsel = opc[2:0]; mode = opc[3]; req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_accept"}, 128'(got), 128'd1);
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1 lat++;
            if (rsp_valid) got = 1'b1;
        end
        check({tag, "_latency"}, 128'(lat), 128'd4);
        if (!got) return;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 128'(rsp_valid), 128'd1);
            check({tag, "_hold_ready"}, 128'(req_ready), 128'd0);
            check({tag, "_hold_result"}, result, exp[131:4]);
            check({tag, "_hold_flags"}, 128'({c_flag, z_flag, o_flag, s_flag}), 128'(exp[3:0]));
        end
        @(negedge clk);
        check({tag, "_result"}, result, exp[131:4]);
        check({tag, "_flags"}, 128'({c_flag, z_flag, o_flag, s_flag}), 128'(exp[3:0]));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 128'(rsp_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(req_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [3:0]   ropc;
        bit           seen;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 128'(req_ready), 128'd0);
        check("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        check("reset_result", result, 128'd0);
        check("reset_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 128'(req_ready), 128'd1);

        run_op(128'hEEEEEEEE, 128'hEEEEEEEE, 4'h6, 0, "addinc");
        check("addinc_const", result, 128'h1_DDDDDDDD);
        run_op('1, 128'd1, 4'h0, 0, "add_wrap");
        run_op(128'd1 << 127, 128'd1, 4'h3, 0, "sub_ovf");
        run_op(128'd1 << 31, '0, 4'hD, 0, "lshl_cross");
        check("lshl_cross_const", result, 128'd1 << 32);
        run_op(128'd1 << 127, '0, 4'hD, 0, "lshl_out");
        run_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'hFFFF, 4'hA, 5, "backpressure");
        run_op('1, '1, 4'hE, 0, "rsv_e");
        run_op('1, '1, 4'h7, 0, "rsv_7");

        // Abort mid-operation: raise rst while slice 2 is being computed.
        @(negedge clk);
        op1 = '1; op2 = '1; opsel = 3'd0; mode = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_rsp_valid", 128'(rsp_valid), 128'd0);
        check("abort_result", result, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 128'(seen), 128'd0);
        run_op(128'd5, 128'd3, 4'h3, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom, $urandom, $urandom};
            rb   = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = '1;
                1: rb = '0;
                2: rb = ra;
                default: ;
            endcase
            ropc = 4'($urandom_range(0, 15));
            run_op(ra, rb, ropc, $urandom_range(0, 2), $sformatf("rand%0d_op%0h", i, ropc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
